// File: rtl/brick_hit_controller_pkg.sv
// Shared types and constants for the brick hit controller and its grid sweeper.
// Holds the FSM state encoding, health levels, default geometry and the saturating decrement.
package brick_hit_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RD_WAIT,
    S_EVAL,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [1:0] HEALTH_NONE = 2'd0;
  localparam logic [1:0] HEALTH_MAX  = 2'd3;

  localparam int         DEF_GRID_W  = 16;
  localparam int         DEF_GRID_H  = 16;
  localparam logic [9:0] DEF_BRICK_W = 10'd40;
  localparam logic [9:0] DEF_BRICK_H = 10'd15;

  // Live-brick counter never wraps below zero.
  function automatic logic [8:0] sat_dec9(input logic [8:0] v);
    return (v == 9'd0) ? 9'd0 : v - 9'd1;
  endfunction

endpackage

// File: rtl/brick_grid_sweeper.sv
// Row-major cell walker for grid fill: column and row counters plus x/y accumulators.
// Outputs the coordinates of the next cell and flags when the current cell is the last one.
module brick_grid_sweeper
  import brick_hit_controller_pkg::*;
#(
  parameter int         GRID_W  = DEF_GRID_W,
  parameter int         GRID_H  = DEF_GRID_H,
  parameter logic [9:0] BRICK_W = DEF_BRICK_W,
  parameter logic [9:0] BRICK_H = DEF_BRICK_H,
  parameter logic [9:0] X0      = 10'd0,
  parameter logic [9:0] Y0      = 10'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [9:0] x_nxt_o,
  output logic [9:0] y_nxt_o,
  output logic       last_cell_o
);

  localparam logic [7:0] COL_LAST = 8'(GRID_W - 1);
  localparam logic [7:0] ROW_LAST = 8'(GRID_H - 1);

  logic [7:0] col_q, col_d, row_q, row_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       wrap;

  assign wrap = (col_q == COL_LAST);

  // Pitch is accumulated rather than multiplied; sums truncate modulo 1024.
  always_comb begin
    col_d = col_q + 8'd1;
    x_d   = x_q + BRICK_W;
    row_d = row_q;
    y_d   = y_q;
    if (wrap) begin
      col_d = 8'd0;
      x_d   = X0;
      row_d = row_q + 8'd1;
      y_d   = y_q + BRICK_H;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      col_q <= 8'd0;
      row_q <= 8'd0;
      x_q   <= X0;
      y_q   <= Y0;
    end else if (en_i) begin
      col_q <= col_d;
      row_q <= row_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign x_nxt_o     = x_d;
  assign y_nxt_o     = y_d;
  assign last_cell_o = wrap && (row_q == ROW_LAST);

endmodule

// File: rtl/brick_hit_controller.sv
// Sequencer for the brick health store: grid fill, read-modify-write hits, live brick count.
// All store-facing outputs and status pulses are registered in a single FSM process.
module brick_hit_controller
  import brick_hit_controller_pkg::*;
#(
  parameter int         GRID_W       = DEF_GRID_W,
  parameter int         GRID_H       = DEF_GRID_H,
  parameter logic [9:0] BRICK_W      = DEF_BRICK_W,
  parameter logic [9:0] BRICK_H      = DEF_BRICK_H,
  parameter logic [9:0] X0           = 10'd0,
  parameter logic [9:0] Y0           = 10'd0,
  parameter logic [1:0] INIT_HEALTH  = HEALTH_MAX,
  parameter int         READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic       hit_req,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  output logic       busy,
  output logic       init_done,
  output logic       hit_done,
  output logic       hit_valid,
  output logic       brick_broken,
  output logic [8:0] bricks_left,
  output logic       all_cleared,
  output logic [9:0] mem_x,
  output logic [9:0] mem_y,
  output logic       mem_wren,
  output logic [1:0] mem_health_w,
  input  logic [1:0] mem_health_r
);

  localparam logic [8:0] START_COUNT =
    (INIT_HEALTH == HEALTH_NONE) ? 9'd0 : 9'(GRID_W * GRID_H);
  localparam logic [7:0] LAT_LAST = 8'(READ_LATENCY - 1);

  state_e     state_q;
  logic       busy_q, init_done_q, hit_done_q, hit_valid_q, brick_broken_q;
  logic       mem_wren_q, inited_q;
  logic [9:0] mem_x_q, mem_y_q;
  logic [1:0] mem_health_w_q, h_q;
  logic [8:0] bricks_left_q;
  logic [7:0] lat_q;

  logic       sw_clr, sw_en, sw_last;
  logic [9:0] sw_x_nxt, sw_y_nxt;

  assign sw_clr = (state_q == S_IDLE) && init_start;
  assign sw_en  = (state_q == S_INIT) && !sw_last;

  brick_grid_sweeper #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .BRICK_W(BRICK_W),
    .BRICK_H(BRICK_H),
    .X0     (X0),
    .Y0     (Y0)
  ) u_sweeper (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (sw_clr),
    .en_i       (sw_en),
    .x_nxt_o    (sw_x_nxt),
    .y_nxt_o    (sw_y_nxt),
    .last_cell_o(sw_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      init_done_q    <= 1'b0;
      hit_done_q     <= 1'b0;
      hit_valid_q    <= 1'b0;
      brick_broken_q <= 1'b0;
      mem_wren_q     <= 1'b0;
      mem_x_q        <= 10'd0;
      mem_y_q        <= 10'd0;
      mem_health_w_q <= 2'd0;
      h_q            <= 2'd0;
      lat_q          <= 8'd0;
      inited_q       <= 1'b0;
      bricks_left_q  <= 9'd0;
    end else begin
      init_done_q    <= 1'b0;
      hit_done_q     <= 1'b0;
      hit_valid_q    <= 1'b0;
      brick_broken_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (init_start) begin
            state_q        <= S_INIT;
            busy_q         <= 1'b1;
            mem_x_q        <= X0;
            mem_y_q        <= Y0;
            mem_wren_q     <= 1'b1;
            mem_health_w_q <= INIT_HEALTH;
          end else if (hit_req) begin
            state_q    <= S_RD_WAIT;
            busy_q     <= 1'b1;
            mem_x_q    <= hit_x;
            mem_y_q    <= hit_y;
            mem_wren_q <= 1'b0;
            lat_q      <= 8'd0;
          end
        end
        S_INIT: begin
          if (sw_last) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            mem_wren_q    <= 1'b0;
            init_done_q   <= 1'b1;
            inited_q      <= 1'b1;
            bricks_left_q <= START_COUNT;
          end else begin
            mem_x_q <= sw_x_nxt;
            mem_y_q <= sw_y_nxt;
          end
        end
        S_RD_WAIT: begin
          if (lat_q == LAT_LAST) state_q <= S_EVAL;
          else                   lat_q   <= lat_q + 8'd1;
        end
        // Read data is valid here; the write is issued for exactly the WRITE cycle.
        S_EVAL: begin
          h_q            <= mem_health_r;
          mem_wren_q     <= (mem_health_r != HEALTH_NONE);
          mem_health_w_q <= mem_health_r - 2'd1;
          state_q        <= S_WRITE;
        end
        S_WRITE: begin
          mem_wren_q     <= 1'b0;
          hit_done_q     <= 1'b1;
          hit_valid_q    <= (h_q != HEALTH_NONE);
          brick_broken_q <= (h_q == 2'd1);
          if (h_q == 2'd1) bricks_left_q <= sat_dec9(bricks_left_q);
          state_q        <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign init_done    = init_done_q;
  assign hit_done     = hit_done_q;
  assign hit_valid    = hit_valid_q;
  assign brick_broken = brick_broken_q;
  assign bricks_left  = bricks_left_q;
  assign all_cleared  = inited_q && (bricks_left_q == 9'd0);
  assign mem_x        = mem_x_q;
  assign mem_y        = mem_y_q;
  assign mem_wren     = mem_wren_q;
  assign mem_health_w = mem_health_w_q;

endmodule

// File: tb/tb_brick_hit_controller.sv
// Scoreboard bench for brick_hit_controller: a 16x16 default instance and a 1x1 instance
// with INIT_HEALTH=1, each backed by a registered-read behavioural health store.
module tb_brick_hit_controller;

  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [1:0] w;} wr_t;
  typedef struct packed {logic valid; logic broken; logic [8:0] left;} res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       init_start = 1'b0, hit_req = 1'b0;
  logic [9:0] hit_x = 10'd0, hit_y = 10'd0;
  logic       busy, init_done, hit_done, hit_valid, brick_broken, all_cleared, mem_wren;
  logic [8:0] bricks_left;
  logic [9:0] mem_x, mem_y;
  logic [1:0] mem_health_w, mem_health_r;

  logic       init_start2 = 1'b0, hit_req2 = 1'b0;
  logic [9:0] hit_x2 = 10'd0, hit_y2 = 10'd0;
  logic       busy2, init_done2, hit_done2, hit_valid2, brick_broken2, all_cleared2, mem_wren2;
  logic [8:0] bricks_left2;
  logic [9:0] mem_x2, mem_y2;
  logic [1:0] mem_health_w2, mem_health_r2;

  logic [1:0] store [0:255];
  logic [1:0] store2;

  int   checks = 0;
  int   failures = 0;
  int   exp_h [0:255];
  int   exp_left = 0;
  bit   exp_init = 1'b0;
  wr_t  wq [$];
  res_t rq [$];

  always #5 clk = ~clk;

  brick_hit_controller dut (
    .clk(clk), .reset(reset), .init_start(init_start), .hit_req(hit_req),
    .hit_x(hit_x), .hit_y(hit_y), .busy(busy), .init_done(init_done),
    .hit_done(hit_done), .hit_valid(hit_valid), .brick_broken(brick_broken),
    .bricks_left(bricks_left), .all_cleared(all_cleared), .mem_x(mem_x),
    .mem_y(mem_y), .mem_wren(mem_wren), .mem_health_w(mem_health_w),
    .mem_health_r(mem_health_r)
  );

  brick_hit_controller #(.GRID_W(1), .GRID_H(1), .INIT_HEALTH(2'd1)) dut2 (
    .clk(clk), .reset(reset), .init_start(init_start2), .hit_req(hit_req2),
    .hit_x(hit_x2), .hit_y(hit_y2), .busy(busy2), .init_done(init_done2),
    .hit_done(hit_done2), .hit_valid(hit_valid2), .brick_broken(brick_broken2),
    .bricks_left(bricks_left2), .all_cleared(all_cleared2), .mem_x(mem_x2),
    .mem_y(mem_y2), .mem_wren(mem_wren2), .mem_health_w(mem_health_w2),
    .mem_health_r(mem_health_r2)
  );

  function automatic int cell_of(input logic [9:0] x, input logic [9:0] y);
    int c, r;
    c = int'(x) / 40;
    r = int'(y) / 15;
    if ((int'(x) % 40 == 0) && (c < 16) && (int'(y) % 15 == 0) && (r < 16)) return r * 16 + c;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (mem_wren) store[cell_of(mem_x, mem_y)] <= mem_health_w;
    mem_health_r <= store[cell_of(mem_x, mem_y)];
    if (mem_wren2) store2 <= mem_health_w2;
    mem_health_r2 <= store2;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, init_done, hit_done, hit_valid, brick_broken, bricks_left, all_cleared,
         mem_x, mem_y, mem_wren, mem_health_w} !== 36'd0) begin
      failures++;
      $display("FAIL reset_dut got busy=%b wren=%b left=%0d x=%0d y=%0d required all zero",
               busy, mem_wren, bricks_left, mem_x, mem_y);
    end
    checks++;
    if ({busy2, init_done2, hit_done2, hit_valid2, brick_broken2, bricks_left2, all_cleared2,
         mem_x2, mem_y2, mem_wren2, mem_health_w2} !== 36'd0) begin
      failures++;
      $display("FAIL reset_dut2 got busy=%b wren=%b left=%0d required all zero",
               busy2, mem_wren2, bricks_left2);
    end
    reset = 1'b0;
  endtask

  task automatic test_init();
    wr_t got, expw;
    int widx = 0, first_i = -1, last_i = -1, done_i = -1, done_cnt = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        wq.push_back(wr_t'{x: 10'(c * 40), y: 10'(r * 15), w: 2'd3});
        exp_h[r * 16 + c] = 3;
      end
    exp_left = 256;
    exp_init = 1'b1;
    @(negedge clk); init_start = 1'b1;
    @(negedge clk); init_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mem_wren) begin
        got = {mem_x, mem_y, mem_health_w};
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL init_write unexpected got=%h", got);
        end else begin
          expw = wq.pop_front();
          if (got !== expw) begin
            failures++;
            $display("FAIL init_write[%0d] got=%h required=%h", widx, got, expw);
          end
        end
        if (widx == 0 || widx == 16 || widx == 255) begin
          checks++;
          if ({mem_x, mem_y} !== ((widx == 0) ? 20'd0 : (widx == 16) ? {10'd0, 10'd15}
                                                  : {10'd600, 10'd225})) begin
            failures++;
            $display("FAIL init_coord[%0d] got=(%0d,%0d)", widx, mem_x, mem_y);
          end
        end
        if (first_i < 0) first_i = i;
        last_i = i;
        widx++;
      end
      if (init_done) begin
        done_cnt++;
        done_i = i;
      end
      @(negedge clk);
    end
    checks++;
    if (widx != 256 || last_i - first_i + 1 != 256) begin
      failures++;
      $display("FAIL init_count got=%0d span=%0d required=256", widx, last_i - first_i + 1);
    end
    checks++;
    if (done_cnt != 1 || done_i != last_i + 1) begin
      failures++;
      $display("FAIL init_done_pulse got count=%0d at=%0d required 1 at %0d", done_cnt, done_i, last_i + 1);
    end
    checks++;
    if ({bricks_left, all_cleared, busy} !== {9'd256, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL init_status got left=%0d cleared=%b busy=%b required 256,0,0",
               bricks_left, all_cleared, busy);
    end
    wq.delete();
  endtask

  task automatic test_hit(input string name, input logic [9:0] x, input logic [9:0] y);
    wr_t got_w, exp_w;
    res_t got_r, exp_r;
    int idx, h, lat;
    idx = cell_of(x, y);
    h = exp_h[idx];
    if (h != 0) begin
      wq.push_back(wr_t'{x: x, y: y, w: 2'(h - 1)});
      exp_h[idx] = h - 1;
    end
    if (h == 1 && exp_left > 0) exp_left--;
    rq.push_back(res_t'{valid: (h != 0), broken: (h == 1), left: 9'(exp_left)});
    @(negedge clk); hit_x = x; hit_y = y; hit_req = 1'b1;
    @(negedge clk); hit_req = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      if (mem_wren) begin
        got_w = {mem_x, mem_y, mem_health_w};
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL %s_write unexpected got=%h required none", name, got_w);
        end else begin
          exp_w = wq.pop_front();
          if (got_w !== exp_w) begin
            failures++;
            $display("FAIL %s_write got=%h required=%h", name, got_w, exp_w);
          end
        end
      end
      if (!hit_done) begin
        checks++;
        if ({hit_valid, brick_broken} !== 2'b00) begin
          failures++;
          $display("FAIL %s_idle_flags got=%b%b required=00", name, hit_valid, brick_broken);
        end
      end else if (lat < 0) begin
        lat = i;
        got_r = {hit_valid, brick_broken, bricks_left};
        exp_r = rq.pop_front();
        checks++;
        if (got_r !== exp_r) begin
          failures++;
          $display("FAIL %s_result got v=%b b=%b left=%0d required v=%b b=%b left=%0d", name,
                   got_r.valid, got_r.broken, got_r.left, exp_r.valid, exp_r.broken, exp_r.left);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=4", name, lat);
    end
    checks++;
    if (wq.size() != 0 || all_cleared !== (exp_init && exp_left == 0)) begin
      failures++;
      $display("FAIL %s_post got pending_writes=%0d cleared=%b", name, wq.size(), all_cleared);
    end
    wq.delete();
    rq.delete();
  endtask

  task automatic test_priority();
    wr_t got_w, exp_w;
    res_t got_r, exp_r;
    int done_i = -1, hit_i = -1, early = 0;
    for (int k = 0; k < 256; k++) begin
      wq.push_back(wr_t'{x: 10'((k % 16) * 40), y: 10'((k / 16) * 15), w: 2'd3});
      exp_h[k] = 3;
    end
    exp_left = 256;
    wq.push_back(wr_t'{x: 10'd0, y: 10'd0, w: 2'd2});
    exp_h[0] = 2;
    rq.push_back(res_t'{valid: 1'b1, broken: 1'b0, left: 9'd256});
    @(negedge clk); init_start = 1'b1; hit_req = 1'b1; hit_x = 10'd0; hit_y = 10'd0;
    @(negedge clk); init_start = 1'b0;
    for (int i = 1; i < 300; i++) begin
      if (mem_wren) begin
        got_w = {mem_x, mem_y, mem_health_w};
        exp_w = (wq.size() != 0) ? wq.pop_front() : 22'h3fffff;
        checks++;
        if (got_w !== exp_w) begin
          failures++;
          $display("FAIL prio_write got=%h required=%h", got_w, exp_w);
        end
      end
      if (init_done) done_i = i;
      if (hit_done) begin
        if (done_i < 0) early++;
        else if (hit_i < 0) begin
          hit_i = i;
          got_r = {hit_valid, brick_broken, bricks_left};
          exp_r = rq.pop_front();
          checks++;
          if (got_r !== exp_r) begin
            failures++;
            $display("FAIL prio_result got=%h required=%h", got_r, exp_r);
          end
        end
      end
      if (done_i > 0 && i == done_i + 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL prio_accept busy got=%b required=1", busy);
        end
        hit_req = 1'b0;
      end
      @(negedge clk);
    end
    hit_req = 1'b0;
    checks++;
    if (early != 0 || done_i < 0 || hit_i != done_i + 4) begin
      failures++;
      $display("FAIL prio_timing got early=%0d done=%0d hit=%0d required hit=done+4", early, done_i, hit_i);
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("FAIL prio_pending got=%0d required=0", wq.size());
    end
    wq.delete();
    rq.delete();
  endtask

  task automatic test_reset_in_write();
    int stray = 0;
    @(negedge clk); hit_x = 10'd80; hit_y = 10'd0; hit_req = 1'b1;
    @(negedge clk); hit_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_wren, mem_x, mem_y, mem_health_w} !== {1'b1, 10'd80, 10'd0, 2'd2}) begin
      failures++;
      $display("FAIL rstw_write got wren=%b x=%0d y=%0d w=%0d required 1,80,0,2",
               mem_wren, mem_x, mem_y, mem_health_w);
    end
    exp_h[2] = 2;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_wren, busy, hit_done, bricks_left, all_cleared} !== 13'd0) begin
      failures++;
      $display("FAIL rstw_state got wren=%b busy=%b done=%b left=%0d cleared=%b required all 0",
               mem_wren, busy, hit_done, bricks_left, all_cleared);
    end
    @(negedge clk); reset = 1'b0;
    exp_left = 0;
    exp_init = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (hit_done || mem_wren || busy) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rstw_after got stray=%0d required=0", stray);
    end
  endtask

  task automatic test_small_hit(input string name, input res_t exp_r, input int exp_writes);
    res_t got_r;
    int lat = -1, nw = 0;
    @(negedge clk); hit_req2 = 1'b1;
    @(negedge clk); hit_req2 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (mem_wren2) begin
        nw++;
        checks++;
        if ({mem_x2, mem_y2, mem_health_w2} !== 22'd0) begin
          failures++;
          $display("FAIL %s_write got x=%0d y=%0d w=%0d required 0,0,0", name, mem_x2, mem_y2, mem_health_w2);
        end
      end
      if (hit_done2 && lat < 0) begin
        lat = i;
        got_r = {hit_valid2, brick_broken2, bricks_left2};
        checks++;
        if (got_r !== exp_r) begin
          failures++;
          $display("FAIL %s_result got=%h required=%h", name, got_r, exp_r);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (lat != 4 || nw != exp_writes || all_cleared2 !== 1'b1) begin
      failures++;
      $display("FAIL %s_post got lat=%0d writes=%0d cleared=%b required 4,%0d,1",
               name, lat, nw, all_cleared2, exp_writes);
    end
  endtask

  task automatic test_small_grid();
    @(negedge clk); init_start2 = 1'b1;
    @(negedge clk); init_start2 = 1'b0;
    checks++;
    if ({mem_wren2, mem_x2, mem_y2, mem_health_w2} !== {1'b1, 10'd0, 10'd0, 2'd1}) begin
      failures++;
      $display("FAIL small_init_write got wren=%b w=%0d required 1,1", mem_wren2, mem_health_w2);
    end
    @(negedge clk);
    checks++;
    if ({init_done2, mem_wren2, bricks_left2, all_cleared2} !== {1'b1, 1'b0, 9'd1, 1'b0}) begin
      failures++;
      $display("FAIL small_init_done got done=%b wren=%b left=%0d cleared=%b required 1,0,1,0",
               init_done2, mem_wren2, bricks_left2, all_cleared2);
    end
    test_small_hit("small_hit1", res_t'{valid: 1'b1, broken: 1'b1, left: 9'd0}, 1);
    test_small_hit("small_hit2", res_t'{valid: 1'b0, broken: 1'b0, left: 9'd0}, 0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_hit("hit1", 10'd40, 10'd0);
    test_hit("hit2", 10'd40, 10'd0);
    test_hit("hit3", 10'd40, 10'd0);
    test_hit("hit4", 10'd40, 10'd0);
    test_priority();
    test_reset_in_write();
    test_small_grid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
